// File: rtl/ai_layer_issuer_if.sv
// Host/decoder-facing signal bundle for ai_layer_issuer.
// Push transfers on any cycle with push_valid && push_ready; start_layer is a one-cycle strobe with no back-pressure.
interface ai_layer_issuer_if #(
  parameter int INST_WIDTH = 32,
  parameter int K_WIDTH    = 4,
  parameter int S_WIDTH    = 4,
  parameter int TYPE_WIDTH = 4,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  push_valid;
  logic                  push_ready;
  logic [TYPE_WIDTH-1:0] push_layer_type;
  logic [K_WIDTH-1:0]    push_kernel_size;
  logic [S_WIDTH-1:0]    push_stride;
  logic                  push_relu_en;
  logic                  push_pool_en;
  logic                  run;
  logic                  flush;
  logic                  layer_done;
  logic                  start_layer;
  logic [INST_WIDTH-1:0] inst_word_out;
  logic                  busy;
  logic [CW-1:0]         fifo_count;
  logic [CNT_W-1:0]      layers_issued;
  logic                  prog_done;
  logic                  err_illegal;
  logic                  timeout;
  logic [1:0]            dbg_state;

  modport master (
    output push_valid, push_layer_type, push_kernel_size, push_stride,
           push_relu_en, push_pool_en, run, flush, layer_done,
    input  push_ready, start_layer, inst_word_out, busy, fifo_count,
           layers_issued, prog_done, err_illegal, timeout, dbg_state
  );

  modport slave (
    input  push_valid, push_layer_type, push_kernel_size, push_stride,
           push_relu_en, push_pool_en, run, flush, layer_done,
    output push_ready, start_layer, inst_word_out, busy, fifo_count,
           layers_issued, prog_done, err_illegal, timeout, dbg_state
  );
endinterface

// File: rtl/ai_layer_issuer.sv
// Layer-descriptor issuer: buffers host descriptors, packs them into words and
// hands them one at a time to the CU decoder, waiting for each layer to finish.
module ai_layer_issuer #(
  parameter int INST_WIDTH  = 32,
  parameter int K_WIDTH     = 4,
  parameter int S_WIDTH     = 4,
  parameter int TYPE_WIDTH  = 4,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 65535,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  ai_layer_issuer_if.slave  bus
);
  localparam int CW       = $clog2(DEPTH + 1);
  localparam int AW       = $clog2(DEPTH);
  localparam int WDW      = $clog2(TIMEOUT_CYC + 1);
  localparam int K_MSB    = INST_WIDTH - TYPE_WIDTH - 1;
  localparam int S_MSB    = K_MSB - K_WIDTH;
  localparam int RELU_BIT = S_MSB - S_WIDTH;
  localparam int POOL_BIT = RELU_BIT - 1;

  if (TYPE_WIDTH + K_WIDTH + S_WIDTH + 2 > INST_WIDTH) begin : g_width_check
    $error("ai_layer_issuer: descriptor fields do not fit in INST_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                state_q;
  logic [INST_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [WDW-1:0]        wd_q;
  logic                  start_q, prog_done_q, err_q, timeout_q;
  logic [INST_WIDTH-1:0] word_q;
  logic [CNT_W-1:0]      layers_q;

  logic                  push_legal, push_fire, push_wr;
  logic                  fifo_avail, start_pop, next_pop, pop, wd_expire;
  logic [INST_WIDTH-1:0] push_word, head_word;

  always_comb begin
    push_word                                = '0;
    push_word[INST_WIDTH-1 -: TYPE_WIDTH]    = bus.push_layer_type;
    push_word[K_MSB -: K_WIDTH]              = bus.push_kernel_size;
    push_word[S_MSB -: S_WIDTH]              = bus.push_stride;
    push_word[RELU_BIT]                      = bus.push_relu_en;
    push_word[POOL_BIT]                      = bus.push_pool_en;
  end

  assign push_legal = (bus.push_kernel_size != '0) && (bus.push_stride != '0);
  assign push_fire  = bus.push_valid && bus.push_ready;
  assign push_wr    = push_fire && push_legal;

  // An empty FIFO can still serve a layer_done pop from the word arriving this cycle.
  assign head_word  = (count_q == '0) ? push_word : mem_q[rd_ptr_q];
  assign fifo_avail = (count_q != '0) || push_wr;
  assign start_pop  = (state_q == IDLE) && bus.run && (count_q != '0);
  assign next_pop   = (state_q == WAIT) && bus.layer_done && fifo_avail;
  assign pop        = start_pop || next_pop;
  assign wd_expire  = (state_q == WAIT) && !bus.layer_done &&
                      (wd_q == WDW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (push_wr) mem_q[wr_ptr_q] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wd_q        <= '0;
      start_q     <= 1'b0;
      word_q      <= '0;
      layers_q    <= '0;
      prog_done_q <= 1'b0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      start_q     <= 1'b0;
      prog_done_q <= 1'b0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
      if (bus.flush) begin
        state_q  <= IDLE;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        wd_q     <= '0;
        layers_q <= '0;
      end else begin
        err_q <= push_fire && !push_legal;
        if (push_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
        if (push_wr && !pop)      count_q <= count_q + CW'(1);
        else if (!push_wr && pop) count_q <= count_q - CW'(1);

        case (state_q)
          IDLE: begin
            if (start_pop) begin
              state_q <= ISSUE;
              word_q  <= head_word;
              start_q <= 1'b1;
            end
          end
          ISSUE: begin
            state_q <= WAIT;
            wd_q    <= '0;
          end
          WAIT: begin
            if (bus.layer_done) begin
              layers_q <= layers_q + CNT_W'(1);
              if (fifo_avail) begin
                state_q <= ISSUE;
                word_q  <= head_word;
                start_q <= 1'b1;
              end else begin
                state_q     <= IDLE;
                prog_done_q <= 1'b1;
              end
            end else if (wd_expire) begin
              state_q   <= IDLE;
              timeout_q <= 1'b1;
              wr_ptr_q  <= '0;
              rd_ptr_q  <= '0;
              count_q   <= '0;
            end else begin
              wd_q <= wd_q + WDW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.push_ready    = (count_q != CW'(DEPTH));
  assign bus.start_layer   = start_q;
  assign bus.inst_word_out = word_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.fifo_count    = count_q;
  assign bus.layers_issued = layers_q;
  assign bus.prog_done     = prog_done_q;
  assign bus.err_illegal   = err_q;
  assign bus.timeout       = timeout_q;
  assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_ai_layer_issuer.sv
// Directed bench for ai_layer_issuer: issued words are checked by a scoreboard
// monitor; state, counters and pulses are checked inline by the main sequence.
module tb_ai_layer_issuer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n_prog = 0, n_err = 0, n_tmo = 0;
  logic [31:0] exp_q[$];

  ai_layer_issuer_if #(.INST_WIDTH(32), .K_WIDTH(4), .S_WIDTH(4), .TYPE_WIDTH(4),
                       .DEPTH(8), .CNT_W(16)) bus ();

  ai_layer_issuer #(.INST_WIDTH(32), .K_WIDTH(4), .S_WIDTH(4), .TYPE_WIDTH(4),
                    .DEPTH(8), .TIMEOUT_CYC(10), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not end, required end before 200000");
    $fatal(1, "time limit");
  end

  function automatic logic [31:0] pack(input int t, input int k, input int s, input bit r, input bit p);
    logic [3:0] t4, k4, s4;
    t4 = t[3:0]; k4 = k[3:0]; s4 = s[3:0];
    return {t4, k4, s4, r, p, 18'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int t, input int k, input int s, input bit r, input bit p);
    bus.push_valid       = 1'b1;
    bus.push_layer_type  = t[3:0];
    bus.push_kernel_size = k[3:0];
    bus.push_stride      = s[3:0];
    bus.push_relu_en     = r;
    bus.push_pool_en     = p;
    tick();
    bus.push_valid = 1'b0;
  endtask

  task automatic do_layer(input int delay, input bit expect_next);
    repeat (delay) tick();
    bus.layer_done = 1'b1;
    tick();
    bus.layer_done = 1'b0;
    check("next_start_latency", {31'b0, bus.start_layer}, {31'b0, expect_next});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_push_ready"}, {31'b0, bus.push_ready}, 32'd1);
    check({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
    check({tag, "_fifo_count"}, {28'b0, bus.fifo_count}, 32'd0);
    check({tag, "_layers"}, {16'b0, bus.layers_issued}, 32'd0);
    check({tag, "_start"}, {31'b0, bus.start_layer}, 32'd0);
    check({tag, "_word"}, bus.inst_word_out, 32'd0);
    check({tag, "_pulses"}, {29'b0, bus.prog_done, bus.err_illegal, bus.timeout}, 32'd0);
    check({tag, "_state"}, {30'b0, bus.dbg_state}, 32'd0);
  endtask

  // Scoreboard monitor: every start_layer must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.start_layer) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start: got word 0x%0h, required no start_layer", bus.inst_word_out);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (bus.inst_word_out !== e) begin
            errors++;
            $display("FAIL issued_word: got 0x%0h expected 0x%0h", bus.inst_word_out, e);
          end
        end
      end
      if (bus.prog_done)   n_prog++;
      if (bus.err_illegal) n_err++;
      if (bus.timeout)     n_tmo++;
    end
  end

  initial begin
    bus.push_valid = 0; bus.push_layer_type = 0; bus.push_kernel_size = 0;
    bus.push_stride = 0; bus.push_relu_en = 0; bus.push_pool_en = 0;
    bus.run = 0; bus.flush = 0; bus.layer_done = 0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Three-layer program with hand-packed words
    exp_q.push_back(32'h1318_0000);
    exp_q.push_back(32'h2224_0000);
    exp_q.push_back(32'h3110_0000);
    push(1, 3, 1, 1, 0);
    push(2, 2, 2, 0, 1);
    push(3, 1, 1, 0, 0);
    check("prog_fifo_count", {28'b0, bus.fifo_count}, 32'd3);
    bus.run = 1'b1;
    tick();
    check("run_latency", {31'b0, bus.start_layer}, 32'd1);
    bus.run = 1'b0;
    do_layer(5, 1'b1);
    do_layer(5, 1'b1);
    do_layer(5, 1'b0);
    check("prog_done_pulse", {31'b0, bus.prog_done}, 32'd1);
    check("prog_layers", {16'b0, bus.layers_issued}, 32'd3);
    check("prog_busy", {31'b0, bus.busy}, 32'd0);
    tick();
    check("prog_done_single", {31'b0, bus.prog_done}, 32'd0);
    check("word_held", bus.inst_word_out, 32'h3110_0000);

    // Illegal descriptors
    push(4, 0, 1, 0, 0);
    check("illegal_k_err", {31'b0, bus.err_illegal}, 32'd1);
    push(4, 1, 0, 0, 0);
    check("illegal_s_err", {31'b0, bus.err_illegal}, 32'd1);
    check("illegal_count", {28'b0, bus.fifo_count}, 32'd0);
    bus.run = 1'b1;
    repeat (3) tick();
    bus.run = 1'b0;
    check("illegal_no_issue", {31'b0, bus.busy}, 32'd0);

    // Fill to full, rejected 9th push, push during ISSUE issued last
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(pack(i, i + 1, (i % 3) + 1, i[0], i[1]));
      push(i, i + 1, (i % 3) + 1, i[0], i[1]);
    end
    check("full_count", {28'b0, bus.fifo_count}, 32'd8);
    check("full_ready", {31'b0, bus.push_ready}, 32'd0);
    push(15, 15, 15, 1, 1);
    check("full_9th_ignored", {28'b0, bus.fifo_count}, 32'd8);
    bus.run = 1'b1;
    tick();
    check("full_issue", {31'b0, bus.start_layer}, 32'd1);
    bus.run = 1'b0;
    exp_q.push_back(pack(9, 9, 9, 1, 0));
    push(9, 9, 9, 1, 0);
    check("pop_push_count", {28'b0, bus.fifo_count}, 32'd8);
    for (int i = 0; i < 9; i++) do_layer(2, i < 8);
    check("full_prog_done", {31'b0, bus.prog_done}, 32'd1);
    check("full_layers", {16'b0, bus.layers_issued}, 32'd12);

    // Watchdog timeout with a queued entry discarded
    exp_q.push_back(32'h671C_0000);
    push(6, 7, 1, 1, 1);
    bus.run = 1'b1;
    tick();
    check("tmo_start", {31'b0, bus.start_layer}, 32'd1);
    bus.run = 1'b0;
    tick();
    push(8, 8, 8, 0, 0);
    repeat (8) tick();
    check("tmo_not_yet", {31'b0, bus.timeout}, 32'd0);
    check("tmo_busy_before", {31'b0, bus.busy}, 32'd1);
    check("tmo_queued", {28'b0, bus.fifo_count}, 32'd1);
    tick();
    check("tmo_pulse", {31'b0, bus.timeout}, 32'd1);
    check("tmo_busy_after", {31'b0, bus.busy}, 32'd0);
    check("tmo_fifo_empty", {28'b0, bus.fifo_count}, 32'd0);
    tick();
    check("tmo_single", {31'b0, bus.timeout}, 32'd0);
    bus.layer_done = 1'b1;
    tick();
    bus.layer_done = 1'b0;
    tick();
    check("tmo_late_done", {16'b0, bus.layers_issued}, 32'd12);

    // Flush during the second WAIT
    exp_q.push_back(32'h4528_0000);
    exp_q.push_back(32'h5134_0000);
    push(4, 5, 2, 1, 0);
    push(5, 1, 3, 0, 1);
    push(6, 2, 2, 0, 0);
    push(7, 3, 3, 1, 1);
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    do_layer(3, 1'b1);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_busy", {31'b0, bus.busy}, 32'd0);
    check("flush_fifo", {28'b0, bus.fifo_count}, 32'd0);
    check("flush_layers", {16'b0, bus.layers_issued}, 32'd0);
    check("flush_pulses", {30'b0, bus.prog_done, bus.start_layer}, 32'd0);
    check("flush_word_held", bus.inst_word_out, 32'h5134_0000);
    bus.layer_done = 1'b1;
    tick();
    bus.layer_done = 1'b0;
    tick();
    check("flush_late_done", {16'b0, bus.layers_issued}, 32'd0);

    // Reset during WAIT with two entries queued
    exp_q.push_back(32'h7220_0000);
    push(7, 2, 2, 0, 0);
    push(1, 1, 1, 0, 0);
    push(2, 1, 1, 0, 0);
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    tick();
    check("rst_in_wait", {30'b0, bus.dbg_state}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("midrst");
    bus.run = 1'b1;
    repeat (3) tick();
    bus.run = 1'b0;
    check("midrst_no_issue", {31'b0, bus.busy}, 32'd0);
    tick();

    check("total_prog_done", n_prog, 32'd2);
    check("total_err_illegal", n_err, 32'd2);
    check("total_timeout", n_tmo, 32'd1);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
